cla_seq_adder: RTL
==================

# cla_seq_adder

Multi-cycle adder/subtractor that is the consumer side of the 4-bit lookahead carry unit. Each cycle it builds per-bit propagate/generate for one 4-bit group and resolves the group's internal carries with the standard lookahead equations. It forms the group's sum bits and registers the group carry-out as the carry-in of the next group. It sits in the ALU datapath as the area-lean alternative to the fully combinational CLA, with a start/busy/done handshake toward the control unit.

## Interface
- WIDTH, 16, operand width in bits. Must be a multiple of 4 and ≥ 4. NG = WIDTH/4 groups.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while idle.
- sub  in  1  1 = a − b (b inverted, carry-in forced 1); 0 = a + b + cin.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; ignored when sub=1.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; results valid.
- sum  out  WIDTH  result.
- cout  out  1  carry out of the MSB. When sub=1: 1 = no borrow.
- ovf  out  1  signed overflow = carry into MSB XOR cout.

## Operation
- FSM states: IDLE and RUN.
- IDLE with start=1 at a clk edge:
  - latch A = a and B = b ^ {WIDTH{sub}};
  - carry register c = sub | cin;
  - group index k = 0; clear the sum register; go to RUN; busy = 1.
- RUN, each edge, for group k (bits 4k+3..4k):
  - P[i] = A[i] ^ B[i], G[i] = A[i] & B[i];
  - c1 = G0 | P0·c
  - c2 = G1 | P1·G0 | P1·P0·c
  - c3 = G2 | P2·G1 | P2·P1·G0 | P2·P1·P0·c
  - c4 = G3 | P3·G2 | P3·P2·G1 | P3·P2·P1·G0 | P3·P2·P1·P0·c
  - sum[4k+3:4k] ← P ^ {c3,c2,c1,c}; c ← c4; k ← k+1.
- Last group (k = NG−1), at the same edge:
  - cout ← c4; ovf ← c3 ^ c4;
  - done ← 1; busy ← 0; state ← IDLE.
- start while busy=1: ignored. Latched operands are unaffected by input changes during RUN.
- sum, cout and ovf hold their values until the next accepted start. At accept, sum clears to 0 and cout/ovf clear to 0.
- rst=1 at an edge, in any state including mid-RUN: state = IDLE, k = 0, c = 0, and every output = 0. The operation in flight is abandoned and no done is issued.
- Carry chain wraps nowhere. Carry out of the top group goes only to cout/ovf.

## Timing
- Reset values: busy = 0, done = 0, sum = 0, cout = 0, ovf = 0.
- start accepted at edge E0 → busy = 1 from E0.
- Group k is resolved at edge E0+k+1.
- done = 1 and busy = 0 after edge E0+NG. For WIDTH = 16, done is high exactly 4 cycles after acceptance.
- done is high for exactly one cycle. start may be asserted in the done cycle; it is accepted at the next edge (back-to-back throughput = NG+1 cycles per operation).
- All outputs are registered. No combinational path from inputs to outputs.
- sum bits of groups not yet processed read 0 while busy.

## Test plan
- Add: a=0x1234, b=0x4321, cin=0, sub=0, start pulse → done 4 cycles later; sum=0x5555, cout=0, ovf=0; busy high for exactly 4 cycles.
- Full ripple: a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. Variant a=0xFFFF, b=0x0000, cin=1 → same result.
- Signed overflow: a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1. Also a=0x8000, b=0x8000 → sum=0x0000, cout=1, ovf=1.
- Subtract: a=0x0005, b=0x0007, sub=1, cin=0 → sum=0xFFFE, cout=0, ovf=0. Also a=0x0007, b=0x0005, sub=1 → sum=0x0002, cout=1.
- Handshake: start held high for 10 cycles with changing operands → only the operands sampled at the first edge are used. done pulses once per accepted op, and the next op is accepted in the done cycle (second done 5 cycles after the first).
- Reset mid-op: rst asserted 2 cycles after accept → next cycle all outputs 0, state IDLE, no done pulse. A subsequent start computes correctly (0x00FF+0x0001 → 0x0100).

Source files
------------

// File: rtl/cla_seq_adder.sv
// Sequential adder/subtractor: resolves one 4-bit lookahead group per clock,
// chaining the group carry-out through a register into the next group.
module cla_seq_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NG = WIDTH / 4;
  localparam int unsigned KW = (NG > 1) ? $clog2(NG) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NG - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] sum_d;
  logic             busy_d, done_d, cout_d, ovf_d;

  logic [3:0]       ga, gb, p, g, s4;
  logic             c1, c2, c3, c4;
  logic [KW+1:0]    sh;

  // Current group slice and its lookahead carries
  assign sh = {k_q, 2'b00};
  assign ga = 4'(a_q >> sh);
  assign gb = 4'(b_q >> sh);
  assign p  = ga ^ gb;
  assign g  = ga & gb;
  assign c1 = g[0] | (p[0] & c_q);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_q);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_q);
  assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & c_q);
  assign s4 = p ^ {c3, c2, c1, c_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      c_q     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      c_q     <= c_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy    <= busy_d;
      done    <= done_d;
      sum     <= sum_d;
      cout    <= cout_d;
      ovf     <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    c_d     = c_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy;
    done_d  = 1'b0;
    sum_d   = sum;
    cout_d  = cout;
    ovf_d   = ovf;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          c_d     = sub | cin;
          k_d     = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Unprocessed groups are still zero, so OR-ing in the new nibble suffices
        sum_d = sum | (WIDTH'(s4) << sh);
        c_d   = c4;
        k_d   = k_q + KW'(1);
        if (k_q == K_LAST) begin
          cout_d  = c4;
          ovf_d   = c3 ^ c4;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          k_d     = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
